// File: rtl/npu_fp16_pkg.sv
// Shared fp16 types, constants and helpers for the NPU datapath stages.
// Arithmetic is round-toward-zero, denormals flush to zero, Inf/NaN clamp to max finite.
package npu_fp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;

    localparam int          FP16_BIAS    = 15;
    localparam logic [15:0] FP16_MAX_POS = 16'h7BFF;
    localparam logic [15:0] FP16_MAX_NEG = 16'hFBFF;
    localparam logic [15:0] FP16_ZERO    = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ADD     = 3'd2,
        ST_BIAS    = 3'd3,
        ST_PRESENT = 3'd4
    } mac_state_t;

    // Zero/denormal becomes +0; Inf/NaN becomes the same-signed largest finite value.
    function automatic fp16_t fp16_sanitize(input logic [15:0] v);
        fp16_t f;
        f = fp16_t'(v);
        if (f.exp == 5'd0) begin
            f = fp16_t'(FP16_ZERO);
        end else if (f.exp == 5'd31) begin
            f = {f.sign, 5'd30, 10'h3FF};
        end
        return f;
    endfunction

    function automatic logic [15:0] fp16_pack(input logic sign,
                                              input logic signed [6:0] exp_r,
                                              input logic [9:0] man);
        if (exp_r <= 7'sd0) begin
            return FP16_ZERO;
        end else if (exp_r >= 7'sd31) begin
            return sign ? FP16_MAX_NEG : FP16_MAX_POS;
        end else begin
            return {sign, exp_r[4:0], man};
        end
    endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational fp16 adder: truncating alignment, leading-zero normalize,
// round-toward-zero, flush/saturate at the exponent limits.
module fp16_add
    import npu_fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    fp16_t             fa;
    fp16_t             fb;
    fp16_t             op_hi;
    fp16_t             op_lo;
    logic [10:0]       sig_hi;
    logic [10:0]       sig_lo;
    logic [10:0]       lo_aligned;
    logic [10:0]       dif;
    logic [11:0]       sum;
    logic [4:0]        shift;
    logic [3:0]        lzc;
    logic signed [6:0] exp_r;
    logic [9:0]        man_r;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path can infer a latch.
        y     = FP16_ZERO;
        exp_r = '0;
        man_r = '0;
        lzc   = 4'd0;

        fa = fp16_sanitize(a);
        fb = fp16_sanitize(b);
        if ({fa.exp, fa.man} >= {fb.exp, fb.man}) begin
            op_hi = fa;
            op_lo = fb;
        end else begin
            op_hi = fb;
            op_lo = fa;
        end

        sig_hi     = (op_hi.exp == 5'd0) ? 11'd0 : {1'b1, op_hi.man};
        sig_lo     = (op_lo.exp == 5'd0) ? 11'd0 : {1'b1, op_lo.man};
        shift      = op_hi.exp - op_lo.exp;
        lo_aligned = (shift >= 5'd12) ? 11'd0 : (sig_lo >> shift);

        sum = {1'b0, sig_hi} + {1'b0, lo_aligned};
        dif = sig_hi - lo_aligned;
        // Lowest-to-highest scan: the last hit is the leading one.
        for (int i = 0; i <= 10; i++) begin
            if (dif[i]) lzc = 4'(10 - i);
        end

        if (op_hi.sign == op_lo.sign) begin
            if (sum != 12'd0) begin
                if (sum[11]) begin
                    exp_r = $signed({2'b00, op_hi.exp}) + 7'sd1;
                    man_r = sum[10:1];
                end else begin
                    exp_r = $signed({2'b00, op_hi.exp});
                    man_r = sum[9:0];
                end
                y = fp16_pack(op_hi.sign, exp_r, man_r);
            end
        end else if (dif != 11'd0) begin
            exp_r = $signed({2'b00, op_hi.exp}) - $signed({3'b000, lzc});
            man_r = 10'(dif << lzc);
            y     = fp16_pack(op_hi.sign, exp_r, man_r);
        end
    end

endmodule

// File: rtl/neuron_mac_fp16.sv
// One neuron pre-activation, sum(x_i*w_i)+bias in fp16, handed to the sigmoid
// stage on a level request held until act_valid.
module neuron_mac_fp16
    import npu_fp16_pkg::*;
#(
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [15:0]      bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_w,
    output logic [15:0]      neuron_val,
    output logic             add_activation,
    input  logic             act_valid,
    output logic             busy
);

    localparam logic signed [6:0] EXP_BIAS7 = 7'(FP16_BIAS);

    mac_state_t       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      bias_q, bias_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic [15:0]      neuron_val_q, neuron_val_d;
    logic             add_activation_q, add_activation_d;

    logic [CNT_W-1:0] num_clamped;
    fp16_t             mx;
    fp16_t             mw;
    logic [21:0]       sig_p;
    logic signed [6:0] exp_p;
    logic [9:0]        man_p;
    logic [15:0]       mul_y;
    logic [15:0]       add_b;
    logic [15:0]       add_y;

    always_comb begin
        mx    = fp16_sanitize(in_x);
        mw    = fp16_sanitize(in_w);
        sig_p = {11'd0, 1'b1, mx.man} * {11'd0, 1'b1, mw.man};
        exp_p = $signed({2'b00, mx.exp}) + $signed({2'b00, mw.exp}) - EXP_BIAS7
              + (sig_p[21] ? 7'sd1 : 7'sd0);
        man_p = sig_p[21] ? 10'(sig_p >> 11) : 10'(sig_p >> 10);
        mul_y = (mx.exp == 5'd0 || mw.exp == 5'd0) ? FP16_ZERO
                                                   : fp16_pack(mx.sign ^ mw.sign, exp_p, man_p);
    end

    // One adder serves both the running sum and the final bias add.
    assign add_b = (state_q == ST_BIAS) ? bias_q : prod_q;

    fp16_add u_add (
        .a (acc_q),
        .b (add_b),
        .y (add_y)
    );

    assign num_clamped = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;

    always_comb begin
        state_d          = state_q;
        num_d            = num_q;
        cnt_d            = cnt_q;
        bias_d           = bias_q;
        acc_d            = acc_q;
        prod_d           = prod_q;
        neuron_val_d     = neuron_val_q;
        add_activation_d = add_activation_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_clamped;
                    bias_d  = bias;
                    acc_d   = FP16_ZERO;
                    cnt_d   = '0;
                    state_d = (num_clamped != '0) ? ST_FETCH : ST_BIAS;
                end
            end
            ST_FETCH: begin
                if (in_valid) begin
                    prod_d  = mul_y;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                acc_d   = add_y;
                state_d = (cnt_q == num_q) ? ST_BIAS : ST_FETCH;
            end
            ST_BIAS: begin
                neuron_val_d     = add_y;
                add_activation_d = 1'b1;
                state_d          = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (act_valid) begin
                    add_activation_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            num_q            <= '0;
            cnt_q            <= '0;
            bias_q           <= FP16_ZERO;
            acc_q            <= FP16_ZERO;
            prod_q           <= FP16_ZERO;
            neuron_val_q     <= FP16_ZERO;
            add_activation_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q          <= state_d;
            num_q            <= num_d;
            cnt_q            <= cnt_d;
            bias_q           <= bias_d;
            acc_q            <= acc_d;
            prod_q           <= prod_d;
            neuron_val_q     <= neuron_val_d;
            add_activation_q <= add_activation_d;
        end
    end

    assign in_ready       = (state_q == ST_FETCH);
    assign busy           = (state_q != ST_IDLE);
    assign neuron_val     = neuron_val_q;
    assign add_activation = add_activation_q;

endmodule

// File: tb/tb_neuron_mac_fp16.sv
// Directed bench for neuron_mac_fp16: a real-valued fp16 model predicts each neuron,
// a negedge compare process checks every output cycle by cycle.
module tb_neuron_mac_fp16;

    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_terms = '0;
    logic [15:0]      bias = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_x = '0;
    logic [15:0]      in_w = '0;
    logic [15:0]      neuron_val;
    logic             add_activation;
    logic             act_valid = 1'b0;
    logic             busy;

    always #5 clk = ~clk;

    neuron_mac_fp16 dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_terms      (num_terms),
        .bias           (bias),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_x           (in_x),
        .in_w           (in_w),
        .neuron_val     (neuron_val),
        .add_activation (add_activation),
        .act_valid      (act_valid),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    endtask

    // ---------------- fp16 reference model in real arithmetic ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_dec(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real r;
        if (e == 0) return 0.0;
        if (e == 31) begin e = 30; m = 1023; end
        r = real'(1024 + m) * pow2(e - 25);
        return h[15] ? -r : r;
    endfunction

    function automatic int log2_floor(input real a);
        int  e = 0;
        real m = a;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return e;
    endfunction

    function automatic logic [15:0] fp_enc(input real v);
        real a;
        int  e;
        int  man;
        if (v == 0.0) return 16'h0000;
        a = (v < 0.0) ? -v : v;
        e = log2_floor(a);
        if (e + 15 >= 31) return (v < 0.0) ? 16'hFBFF : 16'h7BFF;
        if (e + 15 <= 0) return 16'h0000;
        man = $rtoi((a / pow2(e) - 1.0) * 1024.0);
        return {(v < 0.0), 5'(e + 15), 10'(man)};
    endfunction

    function automatic logic [15:0] fp_mul_m(input logic [15:0] a, input logic [15:0] b);
        return fp_enc(fp_dec(a) * fp_dec(b));
    endfunction

    // Smaller operand is first truncated to a multiple of the larger one's ulp.
    function automatic logic [15:0] fp_add_m(input logic [15:0] a, input logic [15:0] b);
        real va = fp_dec(a);
        real vb = fp_dec(b);
        real hi, lo, ulp, lo_t;
        if ((va < 0.0 ? -va : va) >= (vb < 0.0 ? -vb : vb)) begin hi = va; lo = vb; end
        else begin hi = vb; lo = va; end
        if (hi == 0.0) return 16'h0000;
        ulp  = pow2(log2_floor(hi < 0.0 ? -hi : hi) - 10);
        lo_t = real'($rtoi((lo < 0.0 ? -lo : lo) / ulp)) * ulp;
        if (lo < 0.0) lo_t = -lo_t;
        return fp_enc(hi + lo_t);
    endfunction

    // ---------------- expectations and per-cycle compare ----------------
    logic [15:0] exp_val   = 16'h0000;
    logic        exp_busy  = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_act   = 1'b0;
    bit          chk_en    = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",           16'(busy),           16'(exp_busy));
            check("in_ready",       16'(in_ready),       16'(exp_ready));
            check("add_activation", 16'(add_activation), 16'(exp_act));
            check("neuron_val",     neuron_val,          exp_val);
        end
    end

    logic [15:0] px [8];
    logic [15:0] pw [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input logic [15:0] x, input logic [15:0] w);
        px[i] = x;
        pw[i] = w;
    endtask

    // Drives one neuron with in_valid held high; req may exceed the clamp limit.
    task automatic run_neuron(input string name, input int req, input logic [15:0] b,
                              input int hold, input bit noise,
                              input bit use_lit, input logic [15:0] lit);
        int          n;
        int          idx;
        logic [15:0] acc;
        logic [15:0] nv;
        logic [15:0] old;
        n   = (req > 256) ? 256 : req;
        acc = 16'h0000;
        for (int i = 0; i < n; i++) acc = fp_add_m(acc, fp_mul_m(px[i % 8], pw[i % 8]));
        nv  = fp_add_m(acc, b);
        old = exp_val;

        start     = 1'b1;
        num_terms = CNT_W'(req);
        bias      = b;
        in_valid  = 1'b1;
        in_x      = px[0];
        in_w      = pw[0];
        act_valid = noise;
        for (int k = 0; k <= 2 * n + 1; k++) begin
            step();
            start     = 1'b0;
            num_terms = '0;
            bias      = ~b;
            exp_busy  = 1'b1;
            exp_ready = (k % 2 == 0) && (k < 2 * n);
            exp_act   = (k >= 2 * n + 1);
            exp_val   = (k >= 2 * n + 1) ? nv : old;
            act_valid = noise && (k < 2 * n + 1);
            idx       = (k + 1) / 2;
            in_x      = (idx < n) ? px[idx % 8] : 16'h5555;
            in_w      = (idx < n) ? pw[idx % 8] : 16'h4A00;
        end
        if (use_lit) check({name, "_value"}, neuron_val, lit);

        for (int h = 0; h < hold; h++) begin
            act_valid = 1'b0;
            start     = (h % 3 == 0);
            num_terms = CNT_W'(1);
            in_valid  = (h % 2 == 0);
            step();
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        act_valid = 1'b1;
        step();
        act_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_ready = 1'b0;
        exp_act   = 1'b0;
        step();
        step();
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("reset_busy",           16'(busy),           16'h0);
        check("reset_in_ready",       16'(in_ready),       16'h0);
        check("reset_add_activation", 16'(add_activation), 16'h0);
        check("reset_neuron_val",     neuron_val,          16'h0000);
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Normal: 1*2 + 0.5*3 + 0.5 = 4.0
        set_pair(0, 16'h3C00, 16'h4000);
        set_pair(1, 16'h3800, 16'h4200);
        run_neuron("normal", 2, 16'h3800, 0, 1'b0, 1'b1, 16'h4400);

        // Zero terms: bias passes straight through
        run_neuron("zero_terms", 0, 16'hBC00, 2, 1'b1, 1'b1, 16'hBC00);

        // Saturation: max finite * 2
        set_pair(0, 16'h7BFF, 16'h4000);
        run_neuron("saturate", 1, 16'h0000, 0, 1'b1, 1'b1, 16'h7BFF);

        // Cancellation: 1 - 1 gives +0
        set_pair(0, 16'h3C00, 16'h3C00);
        set_pair(1, 16'hBC00, 16'h3C00);
        run_neuron("cancel", 2, 16'h0000, 0, 1'b0, 1'b1, 16'h0000);

        // Back-pressure with normalization and underflow: 1 - 0.75 + flushed tiny + 0.125
        set_pair(0, 16'h3C00, 16'h3C00);
        set_pair(1, 16'hBA00, 16'h3C00);
        set_pair(2, 16'h0400, 16'h3800);
        run_neuron("backpressure", 3, 16'h3000, 20, 1'b0, 1'b1, 16'h3600);

        // Inf clamps to max, denormal flushes, -2 is lost in alignment
        set_pair(0, 16'h7C00, 16'h3C00);
        set_pair(1, 16'h0001, 16'h4000);
        run_neuron("inf_denorm", 2, 16'hC000, 0, 1'b0, 1'b1, 16'h7BFF);

        // Fractional operands, model only
        set_pair(0, 16'h3555, 16'h4248);
        set_pair(1, 16'hC100, 16'h3A66);
        run_neuron("mixed", 2, 16'h2E66, 1, 1'b1, 1'b0, 16'h0000);

        // num_terms above the limit clamps to 256 ones
        for (int i = 0; i < 8; i++) set_pair(i, 16'h3C00, 16'h3C00);
        run_neuron("clamp", 300, 16'h0000, 0, 1'b0, 1'b1, 16'h5C00);

        // Reset in FETCH after one of three pairs
        set_pair(0, 16'h3C00, 16'h4000);
        set_pair(1, 16'h4000, 16'h4000);
        set_pair(2, 16'h4200, 16'h3C00);
        start     = 1'b1;
        num_terms = CNT_W'(3);
        bias      = 16'h3C00;
        in_valid  = 1'b1;
        in_x      = px[0];
        in_w      = pw[0];
        for (int k = 0; k <= 2; k++) begin
            step();
            start     = 1'b0;
            exp_busy  = 1'b1;
            exp_ready = (k % 2 == 0);
            exp_act   = 1'b0;
            in_x      = px[(k + 1) / 2];
            in_w      = pw[(k + 1) / 2];
        end
        #2;
        exp_busy  = 1'b0;
        exp_ready = 1'b0;
        exp_act   = 1'b0;
        exp_val   = 16'h0000;
        reset     = 1'b1;
        #1;
        check("async_rst_busy",           16'(busy),           16'h0);
        check("async_rst_in_ready",       16'(in_ready),       16'h0);
        check("async_rst_add_activation", 16'(add_activation), 16'h0);
        check("async_rst_neuron_val",     neuron_val,          16'h0000);
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();

        // Fresh neuron after reset: 2*2 + 0 = 4.0
        set_pair(0, 16'h4000, 16'h4000);
        run_neuron("after_reset", 1, 16'h0000, 0, 1'b0, 1'b1, 16'h4400);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
